// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset control FSM.
// Optional performance counters are enabled with MC_PERF_CNT_EN.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_JUMP    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_ADDI  = 2'd3;

    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       busy;
    } ctrl_t;

    // States that wait on the memory handshake.
    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Opcode/handshake inputs and datapath control outputs of the controller.
// Counter fields exist only when MC_PERF_CNT_EN is defined.
interface multicycle_ctrl_fsm_if;

    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_write_cond;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_source;
    logic        illegal_op;
    logic        busy;
`ifdef MC_PERF_CNT_EN
    logic [31:0] instr_count;
    logic [31:0] stall_count;
`endif

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, busy
`ifdef MC_PERF_CNT_EN
        , output instr_count, stall_count
`endif
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, busy
`ifdef MC_PERF_CNT_EN
        , input instr_count, stall_count
`endif
    );

endinterface

// File: rtl/multicycle_ctrl_fsm_outdec.sv
// Moore output decoder: state (plus mem_ready in fetch) to datapath control word.
// Unused state encodings decode to an all-zero word.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_RESET: ctrl_o = '0;
            S_FETCH: begin
                ctrl_o.busy      = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC only capture on the cycle the memory delivers.
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.busy      = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl_o.busy      = 1'b1;
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl_o.busy      = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.busy       = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.busy      = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.busy      = 1'b1;
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.busy      = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.busy          = 1'b1;
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_ADDI_EX: begin
                ctrl_o.busy      = 1'b1;
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADDI;
            end
            S_ADDI_WB: begin
                ctrl_o.busy      = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.busy      = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS-subset controller: state register, next-state logic, reset wait.
// Define MC_PERF_CNT_EN to add instruction and memory-stall counters.
module multicycle_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned RESET_VECTOR_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_ctrl_fsm_if.master bus
);

    localparam logic [3:0] WAIT_LAST = 4'(RESET_VECTOR_WAIT - 1);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    ctrl_t      ctrl;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        illegal_d = 1'b0;
        case (state_q)
            S_RESET: begin
                if (wait_q == WAIT_LAST) state_d = S_FETCH;
                else                     wait_d  = wait_q + 4'd1;
            end
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:    state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_ADDI_WB: state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // illegal_op is registered so no output depends on opcode combinationally;
    // it pulses during the first cycle back in S_FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RESET;
            wait_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
        end
    end

    mc_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.busy          = ctrl.busy;
    assign bus.illegal_op    = illegal_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] instr_count_q, instr_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        instr_done;
    logic        mem_stall;

    // Illegal-op returns come from S_DECODE and so never count as completions.
    always_comb begin
        instr_done = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                     (state_q == S_BRANCH) || (state_q == S_ADDI_WB) ||
                     (state_q == S_JUMP) ||
                     ((state_q == S_MEMWR) && bus.mem_ready);
        mem_stall     = is_mem_state(state_q) && !bus.mem_ready;
        instr_count_d = instr_count_q + {31'd0, instr_done};
        stall_count_d = stall_count_q + {31'd0, mem_stall};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            instr_count_q <= instr_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.instr_count = instr_count_q;
    assign bus.stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed scoreboard bench for multicycle_ctrl_fsm (RESET_VECTOR_WAIT=3).
// Counter checks are included when MC_PERF_CNT_EN is defined.
module tb_multicycle_ctrl_fsm;

    localparam int ST_RESET = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3,
                   ST_MEMRD = 4, ST_MEMWB = 5, ST_MEMWR = 6, ST_EXEC = 7,
                   ST_ALUWB = 8, ST_BRANCH = 9, ST_ADDI_EX = 10,
                   ST_ADDI_WB = 11, ST_JUMP = 12;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010,
                           BAD = 6'b111111;

    typedef struct {
        string       tag;
        logic [17:0] ctrl;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t sb_q[$];
    int unsigned exp_instr;
    int unsigned exp_stall;

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm #(.RESET_VECTOR_WAIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [17:0] obs_v = {bus.busy, bus.illegal_op, bus.pc_write, bus.pc_write_cond,
                         bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                         bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                         bus.alu_src_b, bus.alu_op, bus.pc_source};

    // Expected control word per state, in the same bit order as obs_v.
    function automatic logic [17:0] exp_ctrl(input int st, input bit rdy, input bit ill);
        logic       busy = 1'b1, pcw = 1'b0, pcwc = 1'b0, iord = 1'b0, mr = 1'b0;
        logic       mw = 1'b0, irw = 1'b0, m2r = 1'b0, rdst = 1'b0, rw = 1'b0, sa = 1'b0;
        logic [1:0] sb = 2'd0, aop = 2'd0, psrc = 2'd0;
        case (st)
            ST_FETCH:   begin mr = 1'b1; sb = 2'd1; irw = rdy; pcw = rdy; end
            ST_DECODE:  sb = 2'd3;
            ST_MEMADR:  begin sa = 1'b1; sb = 2'd2; end
            ST_MEMRD:   begin mr = 1'b1; iord = 1'b1; end
            ST_MEMWB:   begin rw = 1'b1; m2r = 1'b1; end
            ST_MEMWR:   begin mw = 1'b1; iord = 1'b1; end
            ST_EXEC:    begin sa = 1'b1; aop = 2'd2; end
            ST_ALUWB:   begin rw = 1'b1; rdst = 1'b1; end
            ST_BRANCH:  begin sa = 1'b1; aop = 2'd1; pcwc = 1'b1; psrc = 2'd1; end
            ST_ADDI_EX: begin sa = 1'b1; sb = 2'd2; aop = 2'd3; end
            ST_ADDI_WB: rw = 1'b1;
            ST_JUMP:    begin pcw = 1'b1; psrc = 2'd2; end
            default:    busy = 1'b0;
        endcase
        return {busy, ill, pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, sa, sb, aop, psrc};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters(input string tag);
`ifdef MC_PERF_CNT_EN
        check({tag, "/instr_count"}, bus.instr_count, exp_instr);
        check({tag, "/stall_count"}, bus.stall_count, exp_stall);
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    // One clock cycle: drive inputs, queue expectation, compare, then advance.
    task automatic cyc(input int st, input bit rdy, input logic [5:0] op, input bit ill,
                       input string tag);
        exp_t e;
        exp_t got;
        bus.mem_ready = rdy;
        bus.opcode    = op;
        e.tag  = tag;
        e.ctrl = exp_ctrl(st, rdy, ill);
        sb_q.push_back(e);
        #1;
        got = sb_q.pop_front();
        check(got.tag, {14'd0, obs_v}, {14'd0, got.ctrl});
        check({tag, "/rd_wr_excl"}, {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
        check({tag, "/rw_strobe_excl"},
              {31'd0, bus.reg_write & (bus.mem_read | bus.mem_write)}, 32'd0);
        check_counters(tag);
        if ((st == ST_FETCH || st == ST_MEMRD || st == ST_MEMWR) && !rdy) exp_stall++;
        if (st == ST_MEMWB || st == ST_ALUWB || st == ST_BRANCH || st == ST_ADDI_WB ||
            st == ST_JUMP || (st == ST_MEMWR && rdy)) exp_instr++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        exp_instr     = 0;
        exp_stall     = 0;
        rst           = 1'b1;
        bus.mem_ready = 1'b0;
        bus.opcode    = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {14'd0, obs_v}, 32'd0);
        check_counters("reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(ST_RESET, 1'b1, LW, 1'b0, $sformatf("rst_wait%0d", i));

        // lw, memory always ready
        cyc(ST_FETCH,  1'b1, LW, 1'b0, "lw_fetch");
        cyc(ST_DECODE, 1'b1, LW, 1'b0, "lw_decode");
        cyc(ST_MEMADR, 1'b1, LW, 1'b0, "lw_memadr");
        cyc(ST_MEMRD,  1'b1, LW, 1'b0, "lw_memrd");
        cyc(ST_MEMWB,  1'b1, LW, 1'b0, "lw_memwb");

        // fetch stalled 4 cycles, then R-format
        for (int i = 0; i < 4; i++) cyc(ST_FETCH, 1'b0, RT, 1'b0, $sformatf("fetch_wait%0d", i));
        cyc(ST_FETCH,  1'b1, RT, 1'b0, "r_fetch");
        cyc(ST_DECODE, 1'b1, RT, 1'b0, "r_decode");
        cyc(ST_EXEC,   1'b1, RT, 1'b0, "r_exec");
        cyc(ST_ALUWB,  1'b1, RT, 1'b0, "r_aluwb");

        // sw with two write wait cycles
        cyc(ST_FETCH,  1'b1, SW, 1'b0, "sw_fetch");
        cyc(ST_DECODE, 1'b1, SW, 1'b0, "sw_decode");
        cyc(ST_MEMADR, 1'b1, SW, 1'b0, "sw_memadr");
        cyc(ST_MEMWR,  1'b0, SW, 1'b0, "sw_memwr0");
        cyc(ST_MEMWR,  1'b0, SW, 1'b0, "sw_memwr1");
        cyc(ST_MEMWR,  1'b1, SW, 1'b0, "sw_memwr2");

        // illegal opcode, then back-to-back beq, j, addi
        cyc(ST_FETCH,   1'b1, BAD,  1'b0, "bad_fetch");
        cyc(ST_DECODE,  1'b1, BAD,  1'b0, "bad_decode");
        cyc(ST_FETCH,   1'b1, BEQ,  1'b1, "bad_return_beq_fetch");
        cyc(ST_DECODE,  1'b1, BEQ,  1'b0, "beq_decode");
        cyc(ST_BRANCH,  1'b1, BEQ,  1'b0, "beq_branch");
        cyc(ST_FETCH,   1'b1, J,    1'b0, "j_fetch");
        cyc(ST_DECODE,  1'b1, J,    1'b0, "j_decode");
        cyc(ST_JUMP,    1'b1, J,    1'b0, "j_jump");
        cyc(ST_FETCH,   1'b1, ADDI, 1'b0, "addi_fetch");
        cyc(ST_DECODE,  1'b1, ADDI, 1'b0, "addi_decode");
        cyc(ST_ADDI_EX, 1'b1, ADDI, 1'b0, "addi_ex");
        cyc(ST_ADDI_WB, 1'b1, ADDI, 1'b0, "addi_wb");

        // asynchronous reset while a load waits in S_MEMRD
        cyc(ST_FETCH,  1'b1, LW, 1'b0, "lw2_fetch");
        cyc(ST_DECODE, 1'b1, LW, 1'b0, "lw2_decode");
        cyc(ST_MEMADR, 1'b1, LW, 1'b0, "lw2_memadr");
        cyc(ST_MEMRD,  1'b0, LW, 1'b0, "lw2_memrd_wait");
        bus.mem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        exp_instr = 0;
        exp_stall = 0;
        check("async_rst_outputs", {14'd0, obs_v}, 32'd0);
        check_counters("async_rst");
        @(posedge clk);
        #1;
        check("rst_held_outputs", {14'd0, obs_v}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(ST_RESET, 1'b1, LW, 1'b0, $sformatf("rst2_wait%0d", i));
        cyc(ST_FETCH, 1'b1, LW, 1'b0, "rst2_fetch");

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
